quad_enc_gen: RTL

//   Quadrature encoder signal generator: produces glitch-free A/B lines with a programmed

---
 rtl/quad_enc_gen.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/quad_enc_gen.sv
// quad_enc_gen: quadrature encoder line generator.
// Emits glitch-free registered A/B lines. Each command sets the edge-to-edge
// period (in prescaled fast ticks), the direction and the number of edges.
// It is used to drive the decoder inputs in loopback/self-test builds.
module quad_enc_gen #(
    parameter int PRESC_DIV = 64,
    parameter int PERIOD_W  = 22,
    parameter int STEP_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic [STEP_W-1:0]   cmd_steps,
    input  logic                cmd_dir,
    input  logic                abort,
    output logic                enc_a,
    output logic                enc_b,
    output logic                edge_pulse,
    output logic                busy,
    output logic                done,
    output logic [STEP_W-1:0]   edge_cnt
);

    localparam int                 PRESC_W   = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_nextState;

    logic [PRESC_W-1:0]   r_presc;
    logic                 w_fastTick;

    logic [PERIOD_W-1:0]  r_periodM1;
    logic [PERIOD_W-1:0]  r_periodCnt;
    logic [STEP_W-1:0]    r_steps;
    logic                 r_dir;

    logic                 r_encA;
    logic                 r_encB;
    logic                 r_edgePulse;
    logic                 r_done;
    logic [STEP_W-1:0]    r_edgeCnt;

    logic                 w_accept;
    logic                 w_periodHit;
    logic                 w_edgeDue;
    logic [STEP_W-1:0]    w_cntNext;
    logic                 w_final;
    logic                 w_nextA;
    logic                 w_nextB;

    // Free-running prescaler. Commands never touch it, so edge timing is
    // always quantised to the same fast-tick grid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
        end else if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    assign w_fastTick = (r_presc == PRESC_MAX);

    // Abort takes priority over a new command offered in the same cycle.
    assign w_accept = (r_state == IDLE) && cmd_valid && !abort;

    // An edge is due when the fast tick that completes the period arrives.
    // It is suppressed during an abort and in the cycle that reports done,
    // so the final edge can never be followed by a stray one.
    assign w_periodHit = (r_periodCnt == r_periodM1);
    assign w_edgeDue   = (r_state == RUN) && !abort && !r_done && w_fastTick && w_periodHit;

    // The edge count saturates, so continuous runs never wrap back to zero.
    assign w_cntNext = (r_edgeCnt == {STEP_W{1'b1}}) ? r_edgeCnt : r_edgeCnt + STEP_W'(1);
    assign w_final   = (r_steps != '0) && (w_cntNext == r_steps);

    // Next quadrature phase {A,B}. Exactly one line toggles per step.
    // Up:   00 -> 10 -> 11 -> 01 -> 00
    // Down: 00 -> 01 -> 11 -> 10 -> 00
    always_comb begin
        w_nextA = r_encA;
        w_nextB = r_encB;
        if (r_dir) begin
            w_nextA = ~r_encB;
            w_nextB = r_encA;
        end else begin
            w_nextA = r_encB;
            w_nextB = ~r_encA;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic. RUN is left when the done pulse is visible, so
    // the generator is ready again one cycle after the final edge.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (abort || r_done) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // FSM outputs: handshake and activity flags follow the state directly.
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE:    cmd_ready = 1'b1;
            RUN:     busy      = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    // Latch the command on acceptance. The period is stored minus one, so
    // a zero request behaves as one tick and the compare can never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_periodM1 <= '0;
            r_steps    <= '0;
            r_dir      <= 1'b0;
        end else if (w_accept) begin
            r_periodM1 <= (cmd_period == '0) ? '0 : cmd_period - PERIOD_W'(1);
            r_steps    <= cmd_steps;
            r_dir      <= cmd_dir;
        end
    end

    // Period counter. It restarts on each accept and is cleared on every
    // edge, so successive edges are exactly one period apart with no drift.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_periodCnt <= '0;
        end else if (w_accept) begin
            r_periodCnt <= '0;
        end else if ((r_state == RUN) && w_fastTick) begin
            if (w_periodHit) begin
                r_periodCnt <= '0;
            end else begin
                r_periodCnt <= r_periodCnt + PERIOD_W'(1);
            end
        end
    end

    // Registered quadrature lines plus edge/done pulses. The lines hold
    // their phase between commands, so a reversed command steps back from
    // wherever the previous one stopped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_encA      <= 1'b0;
            r_encB      <= 1'b0;
            r_edgePulse <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_edgePulse <= w_edgeDue;
            r_done      <= w_edgeDue && w_final;
            if (w_edgeDue) begin
                r_encA <= w_nextA;
                r_encB <= w_nextB;
            end
        end
    end

    // Edges emitted by the current or last command. The count holds after
    // completion or abort until the next command is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edgeCnt <= '0;
        end else if (w_accept) begin
            r_edgeCnt <= '0;
        end else if (w_edgeDue) begin
            r_edgeCnt <= w_cntNext;
        end
    end

    assign enc_a      = r_encA;
    assign enc_b      = r_encB;
    assign edge_pulse = r_edgePulse;
    assign done       = r_done;
    assign edge_cnt   = r_edgeCnt;

endmodule
